// File: rtl/armleocpu_ptw_arbiter.sv
// Purpose : two-port (fetch/data) arbiter in front of a single page-table walker.
// Latency : request sampled in IDLE at T -> PTW start pulse at T+1 -> earliest done at T+2.
// Backpressure: a non-granted requester simply holds its level request until served.
//
// Ports:
//   clk, async_rst_n                  - clock, asynchronous active-low reset
//   pN_resolve_request/_virtual_addr  - per-port level request + VPN (N=0 fetch, N=1 data)
//   pN_resolve_done                   - per-port one-cycle completion pulse
//   ptw_resolve_*                     - start pulse + latched VPN out, results/done in
//   resolve_*                         - shared result bus, combinational from the PTW
//   arb_grant, arb_busy               - current/last granted port, walk in flight
//
// Build option: define ARMLEOCPU_PTW_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// left undefined, port 1 (data) has fixed priority over port 0 (fetch).

module armleocpu_ptw_arbiter #(
  parameter int PHYS_W = 22
) (
  input  logic              clk,
  input  logic              async_rst_n,

  input  logic              p0_resolve_request,
  input  logic [19:0]       p0_resolve_virtual_address,
  output logic              p0_resolve_done,

  input  logic              p1_resolve_request,
  input  logic [19:0]       p1_resolve_virtual_address,
  output logic              p1_resolve_done,

  output logic              ptw_resolve_request,
  output logic [19:0]       ptw_resolve_virtual_address,
  input  logic              ptw_resolve_done,
  input  logic              ptw_resolve_pagefault,
  input  logic              ptw_resolve_accessfault,
  input  logic [7:0]        ptw_resolve_access_bits,
  input  logic [PHYS_W-1:0] ptw_resolve_physical_address,

  output logic              resolve_pagefault,
  output logic              resolve_accessfault,
  output logic [7:0]        resolve_access_bits,
  output logic [PHYS_W-1:0] resolve_physical_address,

  output logic              arb_grant,
  output logic              arb_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic [19:0] vpn_q, vpn_d;

  logic        any_req;
  logic        winner;

  // Result bus is a straight passthrough; consumers qualify it with their done pulse.
  assign resolve_pagefault        = ptw_resolve_pagefault;
  assign resolve_accessfault      = ptw_resolve_accessfault;
  assign resolve_access_bits      = ptw_resolve_access_bits;
  assign resolve_physical_address = ptw_resolve_physical_address;

  assign ptw_resolve_virtual_address = vpn_q;
  assign arb_grant                   = grant_q;
  assign arb_busy                    = (state_q != ST_IDLE);

  assign any_req = p0_resolve_request | p1_resolve_request;

  // Winner selection. A lone requester always wins; only the tie case differs.
  always_comb begin
    winner = p1_resolve_request;
`ifdef ARMLEOCPU_PTW_ARB_ROUND_ROBIN_EN
    // Tie goes to the port that did not win last time. grant_q resets to 1,
    // so port 0 takes the first tie after reset.
    if (p0_resolve_request && p1_resolve_request) begin
      winner = ~grant_q;
    end
`endif
  end

  always_comb begin
    state_d             = state_q;
    grant_d             = grant_q;
    vpn_d               = vpn_q;
    ptw_resolve_request = 1'b0;
    p0_resolve_done     = 1'b0;
    p1_resolve_done     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A PTW done seen here is stale/spurious and is dropped.
        if (any_req) begin
          grant_d = winner;
          vpn_d   = winner ? p1_resolve_virtual_address : p0_resolve_virtual_address;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ptw_resolve_request = 1'b1;
        state_d             = ST_WAIT;
      end
      ST_WAIT: begin
        // The walk completes even if the requester has since dropped its
        // request; the latched VPN/grant are what the PTW is working on.
        if (ptw_resolve_done) begin
          p0_resolve_done = ~grant_q;
          p1_resolve_done =  grant_q;
          state_d         = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b1;
      vpn_q   <= 20'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      vpn_q   <= vpn_d;
    end
  end

endmodule

// File: tb/tb_armleocpu_ptw_arbiter.sv
module tb_armleocpu_ptw_arbiter;

  localparam int PHYS_W = 22;

  logic              clk;
  logic              async_rst_n;
  logic              p0_resolve_request;
  logic [19:0]       p0_resolve_virtual_address;
  logic              p0_resolve_done;
  logic              p1_resolve_request;
  logic [19:0]       p1_resolve_virtual_address;
  logic              p1_resolve_done;
  logic              ptw_resolve_request;
  logic [19:0]       ptw_resolve_virtual_address;
  logic              ptw_resolve_done;
  logic              ptw_resolve_pagefault;
  logic              ptw_resolve_accessfault;
  logic [7:0]        ptw_resolve_access_bits;
  logic [PHYS_W-1:0] ptw_resolve_physical_address;
  logic              resolve_pagefault;
  logic              resolve_accessfault;
  logic [7:0]        resolve_access_bits;
  logic [PHYS_W-1:0] resolve_physical_address;
  logic              arb_grant;
  logic              arb_busy;

  armleocpu_ptw_arbiter #(.PHYS_W(PHYS_W)) dut (
    .clk                          (clk),
    .async_rst_n                  (async_rst_n),
    .p0_resolve_request           (p0_resolve_request),
    .p0_resolve_virtual_address   (p0_resolve_virtual_address),
    .p0_resolve_done              (p0_resolve_done),
    .p1_resolve_request           (p1_resolve_request),
    .p1_resolve_virtual_address   (p1_resolve_virtual_address),
    .p1_resolve_done              (p1_resolve_done),
    .ptw_resolve_request          (ptw_resolve_request),
    .ptw_resolve_virtual_address  (ptw_resolve_virtual_address),
    .ptw_resolve_done             (ptw_resolve_done),
    .ptw_resolve_pagefault        (ptw_resolve_pagefault),
    .ptw_resolve_accessfault      (ptw_resolve_accessfault),
    .ptw_resolve_access_bits      (ptw_resolve_access_bits),
    .ptw_resolve_physical_address (ptw_resolve_physical_address),
    .resolve_pagefault            (resolve_pagefault),
    .resolve_accessfault          (resolve_accessfault),
    .resolve_access_bits          (resolve_access_bits),
    .resolve_physical_address     (resolve_physical_address),
    .arb_grant                    (arb_grant),
    .arb_busy                     (arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              port;
    logic [PHYS_W-1:0] ppn;
    logic              pf;
    logic              af;
    logic [7:0]        bits;
  } exp_done_t;

  logic [19:0] exp_vpn_q[$];
  exp_done_t   exp_done_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation each time the DUT presents a PTW start or a done pulse.
  logic [19:0] mon_vpn;
  exp_done_t   mon_e;
  always @(negedge clk) begin
    if (ptw_resolve_request === 1'b1) begin
      if (exp_vpn_q.size() == 0) begin
        check("unexpected_ptw_request", 32'd1, 32'd0);
      end else begin
        mon_vpn = exp_vpn_q.pop_front();
        check("ptw_vpn", {12'd0, ptw_resolve_virtual_address}, {12'd0, mon_vpn});
      end
    end
    if (p0_resolve_done === 1'b1 || p1_resolve_done === 1'b1) begin
      check("done_onehot", {31'd0, p0_resolve_done & p1_resolve_done}, 32'd0);
      if (exp_done_q.size() == 0) begin
        check("unexpected_done", {30'd0, p1_resolve_done, p0_resolve_done}, 32'd0);
      end else begin
        mon_e = exp_done_q.pop_front();
        check("done_port", {30'd0, p1_resolve_done, p0_resolve_done},
              mon_e.port ? 32'd2 : 32'd1);
        check("done_ppn", {10'd0, resolve_physical_address}, {10'd0, mon_e.ppn});
        check("done_pagefault", {31'd0, resolve_pagefault}, {31'd0, mon_e.pf});
        check("done_accessfault", {31'd0, resolve_accessfault}, {31'd0, mon_e.af});
        check("done_bits", {24'd0, resolve_access_bits}, {24'd0, mon_e.bits});
        check("done_busy", {31'd0, arb_busy}, 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ptw_req(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (ptw_resolve_request === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: ptw request not seen within 20 cycles", name);
    end
  endtask

  task automatic ptw_respond(input int dly, input logic [PHYS_W-1:0] ppn,
                             input logic pf, input logic af, input logic [7:0] bits);
    repeat (dly) tick();
    ptw_resolve_done             = 1'b1;
    ptw_resolve_physical_address = ppn;
    ptw_resolve_pagefault        = pf;
    ptw_resolve_accessfault      = af;
    ptw_resolve_access_bits      = bits;
    tick();
    ptw_resolve_done             = 1'b0;
    ptw_resolve_physical_address = '0;
    ptw_resolve_pagefault        = 1'b0;
    ptw_resolve_accessfault      = 1'b0;
    ptw_resolve_access_bits      = 8'd0;
  endtask

  task automatic apply_reset();
    async_rst_n = 1'b0;
    tick();
    tick();
    async_rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ptw_req"}, {31'd0, ptw_resolve_request}, 32'd0);
    check({tag, "_p0_done"}, {31'd0, p0_resolve_done}, 32'd0);
    check({tag, "_p1_done"}, {31'd0, p1_resolve_done}, 32'd0);
    check({tag, "_busy"}, {31'd0, arb_busy}, 32'd0);
    check({tag, "_grant"}, {31'd0, arb_grant}, 32'd1);
    check({tag, "_vpn"}, {12'd0, ptw_resolve_virtual_address}, 32'd0);
  endtask

  logic first_port;

  initial begin
    p0_resolve_request           = 1'b0;
    p0_resolve_virtual_address   = 20'd0;
    p1_resolve_request           = 1'b0;
    p1_resolve_virtual_address   = 20'd0;
    ptw_resolve_done             = 1'b0;
    ptw_resolve_pagefault        = 1'b0;
    ptw_resolve_accessfault      = 1'b0;
    ptw_resolve_access_bits      = 8'd0;
    ptw_resolve_physical_address = '0;
    async_rst_n                  = 1'b1;
    #1 async_rst_n = 1'b0;
    #1;
    // Reset values must appear with no clock edge yet.
    check_reset_outputs("rst0");
    tick();
    tick();
    async_rst_n = 1'b1;

    // Single p0 request, PTW done three cycles after the start pulse.
    exp_vpn_q.push_back(20'h00001);
    exp_done_q.push_back('{port: 1'b0, ppn: 22'h000001, pf: 1'b0, af: 1'b0, bits: 8'h0F});
    p0_resolve_request         = 1'b1;
    p0_resolve_virtual_address = 20'h00001;
    wait_ptw_req("single_p0");
    check("single_grant", {31'd0, arb_grant}, 32'd0);
    check("single_busy", {31'd0, arb_busy}, 32'd1);
    ptw_respond(3, 22'h000001, 1'b0, 1'b0, 8'h0F);
    p0_resolve_request = 1'b0;
    tick();
    check("single_idle_busy", {31'd0, arb_busy}, 32'd0);

    // Simultaneous requests from a fresh reset.
    apply_reset();
`ifdef ARMLEOCPU_PTW_ARB_ROUND_ROBIN_EN
    first_port = 1'b0;
`else
    first_port = 1'b1;
`endif
    for (int k = 0; k < 2; k++) begin
      logic pp;
      pp = (k == 0) ? first_port : ~first_port;
      exp_vpn_q.push_back(pp ? 20'h00002 : 20'h00001);
      exp_done_q.push_back('{port: pp, ppn: pp ? 22'h000200 : 22'h000100,
                             pf: 1'b0, af: 1'b0, bits: 8'h00});
    end
    p0_resolve_virtual_address = 20'h00001;
    p1_resolve_virtual_address = 20'h00002;
    p0_resolve_request         = 1'b1;
    p1_resolve_request         = 1'b1;
    for (int k = 0; k < 2; k++) begin
      logic pp;
      pp = (k == 0) ? first_port : ~first_port;
      wait_ptw_req("both_req");
      check("both_grant", {31'd0, arb_grant}, {31'd0, pp});
      ptw_respond(1, pp ? 22'h000200 : 22'h000100, 1'b0, 1'b0, 8'h00);
      if (pp) p1_resolve_request = 1'b0;
      else    p0_resolve_request = 1'b0;
    end

    // Pagefault returned to p1.
    exp_vpn_q.push_back(20'h00003);
    exp_done_q.push_back('{port: 1'b1, ppn: 22'h2AAAAA, pf: 1'b1, af: 1'b0, bits: 8'h00});
    p1_resolve_virtual_address = 20'h00003;
    p1_resolve_request         = 1'b1;
    wait_ptw_req("pagefault_p1");
    ptw_respond(2, 22'h2AAAAA, 1'b1, 1'b0, 8'h00);
    p1_resolve_request = 1'b0;

    // Access fault plus flag bits to p0.
    exp_vpn_q.push_back(20'hABCDE);
    exp_done_q.push_back('{port: 1'b0, ppn: 22'h0F0F0F, pf: 1'b0, af: 1'b1, bits: 8'hCF});
    p0_resolve_virtual_address = 20'hABCDE;
    p0_resolve_request         = 1'b1;
    wait_ptw_req("accessfault_p0");
    ptw_respond(1, 22'h0F0F0F, 1'b0, 1'b1, 8'hCF);
    p0_resolve_request = 1'b0;

    // p0 drops its request and changes its VPN mid-walk.
    exp_vpn_q.push_back(20'h00010);
    exp_done_q.push_back('{port: 1'b0, ppn: 22'h155555, pf: 1'b0, af: 1'b0, bits: 8'h5B});
    p0_resolve_virtual_address = 20'h00010;
    p0_resolve_request         = 1'b1;
    wait_ptw_req("drop_p0");
    tick();
    p0_resolve_request         = 1'b0;
    p0_resolve_virtual_address = 20'h0FFFF;
    tick();
    check("drop_vpn_held", {12'd0, ptw_resolve_virtual_address}, 32'h00010);
    check("drop_grant_held", {31'd0, arb_grant}, 32'd0);
    check("drop_busy", {31'd0, arb_busy}, 32'd1);
    ptw_respond(1, 22'h155555, 1'b0, 1'b0, 8'h5B);

    // Reset during WAIT, then a spurious done after release.
    exp_vpn_q.push_back(20'h00005);
    p1_resolve_virtual_address = 20'h00005;
    p1_resolve_request         = 1'b1;
    wait_ptw_req("reset_wait");
    tick();
    check("reset_wait_busy", {31'd0, arb_busy}, 32'd1);
    async_rst_n        = 1'b0;
    p1_resolve_request = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    tick();
    tick();
    async_rst_n = 1'b1;
    check("post_rst_grant", {31'd0, arb_grant}, 32'd1);
    check("post_rst_busy", {31'd0, arb_busy}, 32'd0);
    ptw_respond(0, 22'h3FFFFF, 1'b1, 1'b1, 8'hFF);
    tick();
    check("post_rst_spurious_busy", {31'd0, arb_busy}, 32'd0);

    // Done in IDLE with no requests is ignored.
    ptw_respond(0, 22'h000777, 1'b0, 1'b0, 8'h00);
    tick();
    check("idle_done_busy", {31'd0, arb_busy}, 32'd0);
    check("idle_done_ptw_req", {31'd0, ptw_resolve_request}, 32'd0);

    // Done during ISSUE is ignored; the real done later completes the walk.
    exp_vpn_q.push_back(20'h00007);
    exp_done_q.push_back('{port: 1'b0, ppn: 22'h000077, pf: 1'b0, af: 1'b0, bits: 8'h01});
    p0_resolve_virtual_address = 20'h00007;
    p0_resolve_request         = 1'b1;
    wait_ptw_req("issue_done");
    ptw_resolve_done = 1'b1;
    tick();
    ptw_resolve_done = 1'b0;
    check("issue_done_still_busy", {31'd0, arb_busy}, 32'd1);
    ptw_respond(2, 22'h000077, 1'b0, 1'b0, 8'h01);
    p0_resolve_request = 1'b0;

    repeat (3) tick();
    check("vpn_queue_drained", exp_vpn_q.size(), 32'd0);
    check("done_queue_drained", exp_done_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
